// File: rtl/matriz_pkg.sv
// Shared types, default parameters and helpers for the LED matrix scanner.
package matriz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE,
    ST_STATIC
  } state_t;

  localparam int unsigned DEF_N_COLS    = 7;
  localparam int unsigned DEF_N_ROWS    = 5;
  localparam int unsigned DEF_DWELL     = 50000;
  localparam int unsigned DEF_BLANK_CYC = 1;

  // Width of one column's slice inside the packed frame word.
  function automatic int unsigned col_slice_w(input int unsigned n_rows);
    return n_rows;
  endfunction

  // Larger of two unsigned values, used for counter sizing.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matriz_col_dec.sv
// Index + valid to active-low one-hot column enable.
module matriz_col_dec
  import matriz_pkg::*;
#(
  parameter int unsigned N_COLS = DEF_N_COLS,
  parameter int unsigned IDX_W  = $clog2(DEF_N_COLS + 1)
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic              valid,
  output logic [N_COLS-1:0] col_n_c
);

  // Pull exactly one column low when the index is valid and in range.
  always_comb begin
    col_n_c = '1;
    for (int c = 0; c < N_COLS; c++) begin
      if (valid && (idx == IDX_W'(c))) col_n_c[c] = 1'b0;
    end
  end

endmodule

// File: rtl/matriz_scanner.sv
// Time-multiplexed LED matrix column driver with double-buffered frame and static select.
module matriz_scanner
  import matriz_pkg::*;
#(
  parameter int unsigned N_COLS    = DEF_N_COLS,
  parameter int unsigned N_ROWS    = DEF_N_ROWS,
  parameter int unsigned DWELL     = DEF_DWELL,
  parameter int unsigned BLANK_CYC = DEF_BLANK_CYC,
  parameter int unsigned SEL_W     = $clog2(N_COLS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       load,
  input  logic [N_COLS*N_ROWS-1:0]   frame,
  output logic [N_COLS-1:0]          col_n,
  output logic [N_ROWS-1:0]          row,
  output logic                       frame_done
);

  localparam int unsigned ROW_W   = col_slice_w(N_ROWS);
  localparam int unsigned FRAME_W = N_COLS * ROW_W;
  localparam int unsigned COL_W   = $clog2(N_COLS);
  localparam int unsigned CNT_W   = $clog2(max_u(DWELL, BLANK_CYC) + 1);

  state_t              st, st_d;
  logic [COL_W-1:0]    col_idx, col_idx_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [FRAME_W-1:0]  shadow, pending;
  logic                pend_flag;
  logic                swap;
  logic                frame_done_d;
  logic                sel_ok;
  logic [SEL_W-1:0]    dec_idx;
  logic                dec_valid;
  logic [N_COLS-1:0]   dec_col_n;
  logic [ROW_W-1:0]    row_d;

  assign sel_ok = (sel != '0) && (sel <= SEL_W'(N_COLS));

  // Next-state, counter and column index; mode/enable changes abandon the scan.
  always_comb begin
    st_d         = st;
    col_idx_d    = col_idx;
    cnt_d        = cnt;
    frame_done_d = 1'b0;
    swap         = 1'b0;
    if (!enable) begin
      st_d      = ST_IDLE;
      col_idx_d = '0;
      cnt_d     = '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (mode) begin
            st_d  = ST_STATIC;
            cnt_d = '0;
          end else begin
            st_d      = ST_BLANK;
            col_idx_d = '0;
            cnt_d     = CNT_W'(BLANK_CYC - 1);
          end
        end
        ST_BLANK: begin
          if (mode) begin
            st_d      = ST_STATIC;
            col_idx_d = '0;
            cnt_d     = '0;
          end else if (cnt == '0) begin
            st_d  = ST_DRIVE;
            cnt_d = CNT_W'(DWELL - 1);
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (mode) begin
            st_d      = ST_STATIC;
            col_idx_d = '0;
            cnt_d     = '0;
          end else if (cnt == '0) begin
            st_d  = ST_BLANK;
            cnt_d = CNT_W'(BLANK_CYC - 1);
            if (col_idx == COL_W'(N_COLS - 1)) begin
              col_idx_d    = '0;
              frame_done_d = 1'b1;
              swap         = pend_flag;
            end else begin
              col_idx_d = col_idx + COL_W'(1);
            end
          end else begin
            cnt_d = cnt - COL_W'(0) - CNT_W'(1);
          end
        end
        ST_STATIC: begin
          swap = pend_flag;
          if (!mode) begin
            st_d      = ST_BLANK;
            col_idx_d = '0;
            cnt_d     = CNT_W'(BLANK_CYC - 1);
          end
        end
        default: begin
          st_d      = ST_IDLE;
          col_idx_d = '0;
          cnt_d     = '0;
        end
      endcase
    end
  end

  // Output decode for the upcoming state, so the registered outputs track the state register.
  always_comb begin
    dec_idx   = '0;
    dec_valid = 1'b0;
    row_d     = '0;
    case (st_d)
      ST_DRIVE: begin
        dec_idx   = SEL_W'(col_idx_d);
        dec_valid = 1'b1;
        for (int c = 0; c < N_COLS; c++) begin
          if (col_idx_d == COL_W'(c)) row_d = shadow[c*ROW_W +: ROW_W];
        end
      end
      ST_STATIC: begin
        if (sel_ok) begin
          dec_idx   = sel - SEL_W'(1);
          dec_valid = 1'b1;
          for (int c = 0; c < N_COLS; c++) begin
            if (sel == SEL_W'(c + 1)) row_d = shadow[c*ROW_W +: ROW_W];
          end
        end
      end
      default: ;
    endcase
  end

  matriz_col_dec #(
    .N_COLS (N_COLS),
    .IDX_W  (SEL_W)
  ) u_col_dec (
    .idx     (dec_idx),
    .valid   (dec_valid),
    .col_n_c (dec_col_n)
  );

  // State register and registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_IDLE;
      col_idx    <= '0;
      cnt        <= '0;
      col_n      <= '1;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      st         <= st_d;
      col_idx    <= col_idx_d;
      cnt        <= cnt_d;
      col_n      <= dec_col_n;
      row        <= row_d;
      frame_done <= frame_done_d;
    end
  end

  // Double buffer: a load always lands in pending; a swap takes the pre-load pending value.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (swap) shadow <= pending;
      if (load) begin
        pending   <= frame;
        pend_flag <= 1'b1;
      end else if (swap) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matriz_scanner.sv
// Scoreboard bench for matriz_scanner: stimulus queues expected pin values, monitor compares each cycle.
module tb_matriz_scanner;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [3:0]  sel;
  logic        load;
  logic [34:0] frame_in;
  logic [6:0]  col_n;
  logic [4:0]  row;
  logic        frame_done;

  typedef struct {
    int         id;
    logic [6:0] c;
    logic [4:0] r;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  matriz_scanner #(
    .N_COLS    (7),
    .N_ROWS    (5),
    .DWELL     (4),
    .BLANK_CYC (1),
    .SEL_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .sel        (sel),
    .load       (load),
    .frame      (frame_in),
    .col_n      (col_n),
    .row        (row),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle just after the edge, pop the expected pin state and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (col_n !== e.c || row !== e.r || frame_done !== e.fd) begin
          errors++;
          $display("FAIL step %0d: col_n=%h row=%h frame_done=%b, expected col_n=%h row=%h frame_done=%b",
                   e.id, col_n, row, frame_done, e.c, e.r, e.fd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [34:0] mk(input int base, input int stp);
    logic [34:0] f;
    f = '0;
    for (int c = 0; c < 7; c++) f[c*5 +: 5] = 5'(base + stp * c);
    return f;
  endfunction

  function automatic logic [4:0] colv(input logic [34:0] f, input int c);
    return f[c*5 +: 5];
  endfunction

  function automatic logic [6:0] col_pat(input int c);
    logic [6:0] p;
    p = 7'h7F;
    p[c] = 1'b0;
    return p;
  endfunction

  // Queue the expected outputs after the coming edge, then move to the next falling edge.
  task automatic cyc(input logic [6:0] c, input logic [4:0] r, input logic fd);
    exp_t e;
    e.id = step_id;
    e.c  = c;
    e.r  = r;
    e.fd = fd;
    q.push_back(e);
    step_id++;
    @(negedge clk);
  endtask

  // One column: a blank cycle then nd drive cycles; optional load on the blank or first drive cycle.
  task automatic scan_col(input int c, input logic [4:0] rv, input logic fd,
                          input logic ldb, input logic ldd, input int nd);
    load = ldb;
    cyc(7'h7F, 5'h00, fd);
    load = 1'b0;
    for (int i = 0; i < nd; i++) begin
      load = ldd && (i == 0);
      cyc(col_pat(c), rv, 1'b0);
      load = 1'b0;
    end
  endtask

  task automatic scan_frame(input logic [34:0] f, input logic fd0, input logic ldb0, input int ldd_col);
    for (int c = 0; c < 7; c++)
      scan_col(c, colv(f, c), (c == 0) ? fd0 : 1'b0, (c == 0) ? ldb0 : 1'b0, c == ldd_col, 4);
  endtask

  initial begin
    logic [34:0] f_zero, f_inc, f_1f, f_b, f_d;
    f_zero = '0;
    f_inc  = mk(1, 1);
    f_1f   = mk(31, 0);
    f_b    = mk(16, 1);
    f_d    = mk(9, 1);

    reset = 1'b1; enable = 1'b0; mode = 1'b0; sel = 4'd0; load = 1'b0; frame_in = f_inc;

    // Reset and idle
    repeat (2) cyc(7'h7F, 5'h00, 1'b0);
    reset = 1'b0;
    repeat (10) cyc(7'h7F, 5'h00, 1'b0);

    // Load 1..7 into pending; the first scan frame still shows the reset shadow
    load = 1'b1;
    cyc(7'h7F, 5'h00, 1'b0);
    load = 1'b0;
    enable = 1'b1;
    scan_frame(f_zero, 1'b0, 1'b0, -1);

    // Swap at frame boundary shows 1..7; load all-1F during column 3
    frame_in = f_1f;
    scan_frame(f_inc, 1'b1, 1'b0, 3);

    // All-1F frame; a load on the swap cycle lands one frame later
    frame_in = f_b;
    scan_frame(f_1f, 1'b1, 1'b1, -1);
    scan_frame(f_b, 1'b1, 1'b0, -1);
    scan_col(0, colv(f_b, 0), 1'b1, 1'b0, 1'b0, 4);
    scan_col(1, colv(f_b, 1), 1'b0, 1'b0, 1'b0, 4);

    // Static select mid-scan, including out-of-range codes
    mode = 1'b1;
    sel = 4'd0;  cyc(7'h7F, 5'h00, 1'b0);
    sel = 4'd1;  cyc(7'h7E, 5'h10, 1'b0);
    sel = 4'd7;  cyc(7'h3F, 5'h16, 1'b0);
    sel = 4'd8;  cyc(7'h7F, 5'h00, 1'b0);
    sel = 4'd15; cyc(7'h7F, 5'h00, 1'b0);

    // Static load: shadow updates one cycle after the pending write
    sel = 4'd2; frame_in = f_d; load = 1'b1;
    cyc(7'h7D, 5'h11, 1'b0);
    load = 1'b0;
    cyc(7'h7D, 5'h11, 1'b0);
    cyc(7'h7D, 5'h0A, 1'b0);

    // Back to scan from column 0, then drop enable during column 4
    mode = 1'b0;
    for (int c = 0; c < 4; c++) scan_col(c, colv(f_d, c), 1'b0, 1'b0, 1'b0, 4);
    scan_col(4, colv(f_d, 4), 1'b0, 1'b0, 1'b0, 2);
    enable = 1'b0;
    repeat (5) cyc(7'h7F, 5'h00, 1'b0);

    // Re-enable restarts at column 0; reset during column 5 with a load pending
    enable = 1'b1;
    for (int c = 0; c < 5; c++) scan_col(c, colv(f_d, c), 1'b0, 1'b0, 1'b0, 4);
    frame_in = f_1f;
    scan_col(5, colv(f_d, 5), 1'b0, 1'b0, 1'b1, 1);
    reset = 1'b1;
    cyc(7'h7F, 5'h00, 1'b0);
    reset = 1'b0;
    scan_frame(f_zero, 1'b0, 1'b0, -1);
    scan_col(0, 5'h00, 1'b1, 1'b0, 1'b0, 4);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matriz_scanner.md
# matriz_scanner

Parametrised, time-multiplexed column driver for the LED matrix. It cycles an active-low one-hot column enable across `N_COLS` columns and presents each column's row pattern from a double-buffered frame. A static mode keeps the existing func-select behaviour: code 0 blanks the matrix and code k drives column k-1. The block sits between the frame-generation logic and the matrix pins.

## Interface
- `N_COLS`, 7: number of columns, 2..16.
- `N_ROWS`, 5: rows per column, 1..16.
- `DWELL`, 50000: cycles each column is driven in scan mode, ≥1.
- `BLANK_CYC`, 1: all-off cycles before each column, ≥1.
- `SEL_W`, $clog2(N_COLS+1): width of the static select code.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: 0 forces blank/IDLE.
- `mode`  in  1: 0 = scan, 1 = static select.
- `sel`  in  SEL_W: static code. 0 = blank; k in 1..N_COLS = column k-1; >N_COLS = blank.
- `load`  in  1: one-cycle pulse that captures `frame` into the pending buffer.
- `frame`  in  N_COLS*N_ROWS: column c occupies bits [c*N_ROWS +: N_ROWS].
- `col_n`  out  N_COLS: active-low one-hot column enable, registered.
- `row`  out  N_ROWS: active-high row data for the driven column, registered.
- `frame_done`  out  1: one-cycle pulse at the end of the last column's dwell.

## Operation
- **Reset:**
  - `col_n` = all 1s, `row` = 0, `frame_done` = 0.
  - Shadow and pending buffers = 0, pending flag = 0.
  - State IDLE, col_idx = 0, counter = 0.
- **States:** IDLE, BLANK, DRIVE, STATIC.
- **IDLE** (enable=0): outputs blank.
  - enable=1, mode=0 → BLANK with col_idx=0.
  - enable=1, mode=1 → STATIC.
- **BLANK:** `col_n` all 1s, `row` 0 for BLANK_CYC cycles, then → DRIVE.
- **DRIVE:** `col_n[col_idx]`=0, `row` = shadow[col_idx], for DWELL cycles. At the end of dwell:
  - col_idx < N_COLS-1: col_idx+1, → BLANK.
  - col_idx = N_COLS-1: col_idx wraps to 0, `frame_done` pulses, pending copied to shadow if the flag is set (flag cleared), → BLANK.
- **STATIC:** each cycle, `col_n`/`row` are the registered decode of `sel` against shadow. If the pending flag is set, pending is copied to shadow immediately (no frame boundary exists).
- **Load:**
  - `load`=1 writes `frame` into pending and sets the flag.
  - A second load before the swap overwrites pending (last wins).
  - Load on the same cycle as a swap: the swap uses the old pending value; the new value is stored and the flag stays set.
- **Mode/enable changes:**
  - enable falling → IDLE next cycle, blank outputs.
  - mode 0→1 mid-scan → scan abandoned, STATIC.
  - mode 1→0 → BLANK, col_idx=0.
  - A `frame_done` is never generated for an abandoned frame.
- **Reset mid-scan:** all state returns to reset values on the next edge; the pending frame is lost.

## Timing
- All outputs are registered.
- STATIC latency: `sel` change to `col_n`/`row` is 1 cycle.
- Scan column period = BLANK_CYC + DWELL cycles.
- Frame period = N_COLS*(BLANK_CYC+DWELL) cycles.
- `frame_done` is high in the first BLANK cycle of the next frame's column 0.
- The new shadow is visible from the next DRIVE of column 0.
- Dwell counter width is $clog2(max(DWELL,BLANK_CYC)+1). The counter reloads on every state entry and never wraps.
- Two columns are never driven low simultaneously. Every column transition includes ≥BLANK_CYC all-high cycles.

## Structure
- Package `matriz_pkg`:
  - state encoding (IDLE, BLANK, DRIVE, STATIC);
  - default parameter constants;
  - helper function returning the column slice width.
- Sub-module `matriz_col_dec`: combinational decoder from index + valid bit to active-low one-hot of N_COLS. It is shared by DRIVE (index = col_idx) and STATIC (index = sel-1, valid = 1 ≤ sel ≤ N_COLS).

## Test plan
Bench parameters: N_COLS=7, N_ROWS=5, DWELL=4, BLANK_CYC=1.

- **Reset/idle:** reset, then enable=0 for 10 cycles → `col_n`=7'h7F, `row`=0, `frame_done`=0 throughout.
- **Full scan:** load frame with column c = c+1, then enable=1, mode=0.
  - `col_n` sequence 7F, 7E×4, 7F, 7D×4, … 3F×4.
  - `row` = 1..7 during the respective dwells.
  - `frame_done` pulses once every 35 cycles.
- **Double buffer:** load new frame (all 5'h1F) during column 3.
  - Old data is shown through column 6.
  - 1F appears from column 0 of the next frame.
  - Load on the swap cycle: the second value appears one frame later.
- **Static:** mode=1, sel = 0, 1, 7, 8 → `col_n` = 7F, 7E, 3F, 7F, each one cycle after `sel`. `row` matches shadow for sel 1/7 and is 0 otherwise.
- **Abort:**
  - enable→0 during column 4 → blank next cycle, no `frame_done`.
  - Re-enable → scan restarts at column 0 after one BLANK cycle.
- **Reset mid-scan:** reset during column 5 with load pending → outputs blank next cycle, shadow = 0 after re-enable.
